bsc_counter_arbiter: RTL and testbench
======================================

Name: bsc_counter_arbiter

Overview:
Shares the two increment ports and the load/set ports of an N-bit two-port-add counter primitive among NREQ requesters plus one configuration writer. Each cycle it grants up to two add requests in round-robin order, merges them with a pending load or force-set, and drives the counter's control and data inputs from a registered issue stage. Instantiated beside the counter primitive; the counter's output is not fed back into this block.

Parameters:
WIDTH, 16, counter and delta width in bits
NREQ, 4, number of add requesters; legal range 2..16

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  add-grant enable; 0 blocks all add grants
req_valid  input  NREQ  per-requester add request
req_delta  input  NREQ*WIDTH  per-requester delta; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  per-requester grant (combinational)
wr_valid  input  1  configuration write request
wr_force  input  1  1 = force-set (exclusive), 0 = load (combinable with adds)
wr_data  input  WIDTH  write value
wr_ready  output  1  write accept (combinational)
add_a  output  1  to counter add_a
add_b  output  1  to counter add_b
set_c  output  1  to counter set_c
set_f  output  1  to counter set_f
data_a  output  WIDTH  to counter data_a
data_b  output  WIDTH  to counter data_b
data_c  output  WIDTH  to counter data_c
data_f  output  WIDTH  to counter data_f
grant_count  output  2  number of adds issued in the current issue-stage cycle (0..2)

Behaviour:
- Reset: synchronous, active-high. While reset is high: all counter-side outputs 0, grant_count 0, round-robin pointer ptr = 0, req_ready = 0, wr_ready = 0. Reset wins over every request. Nothing accepted before reset is issued afterwards; the issue stage clears.
- Handshake: a transfer occurs when valid && ready in the same cycle. ready never depends on ready. valid may be dropped without a transfer.
- wr_ready = wr_valid && !reset. A write is always accepted in the cycle it is presented.
- Force write (wr_valid && wr_force): no add grants that cycle; all req_ready = 0; ptr unchanged.
- Otherwise, when en = 1, scan requesters ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ). The first valid requester is grant A and the second is grant B. At most two grants are made; req_ready is high only for granted requesters.
- Pointer update: if at least one grant is made, ptr <= (index of last granted + 1) mod NREQ. If there are no grants, ptr holds.
- en = 0: no add grants; ptr holds; load and force writes still proceed.
- Issue stage (one register stage): a bundle accepted in cycle N drives the counter ports throughout cycle N+1. The counter value reflects it after the clock edge ending N+1, giving 2-cycle acceptance-to-visible latency.
  - add_a / data_a = grant A and its delta.
  - add_b / data_b = grant B and its delta.
  - set_c / data_c = load write.
  - set_f / data_f = force write.
- Unused data outputs are driven to 0. With only one grant, it always goes to port A.
- In cycles with nothing accepted, the stage issues all zeros.
- Arithmetic is performed by the counter: (set_c ? data_c : q) + A + B, modulo 2^WIDTH. The arbiter does no saturation and does not inspect deltas. A delta of 0 is still a grant.
- grant_count = add_a + add_b of the current issue stage.
- Single requester valid: granted every cycle on port A; ptr moves to that index + 1.
- Wrap-around: scan and pointer arithmetic are modulo NREQ. A requester at index NREQ-1 followed by index 0 is a legal A/B pair.

Test Plan:
- Reset held 3 cycles with all requests valid -> all outputs 0, no req_ready. First cycle after reset, NREQ=4, all valid -> grants 0 (A) and 1 (B); next cycle grants 2 and 3; next cycle grants 0 and 1.
- WIDTH=8, req_valid=4'b1000, delta 8'h05, ptr=0 -> req_ready=4'b1000. Next cycle add_a=1, data_a=5, add_b=0, grant_count=1. ptr becomes 0. Counter at INIT 0 reads 5 two cycles after acceptance.
- ptr=3, req_valid=4'b1001 -> A=3, B=0 (wrap). Deltas 8'hFF and 8'h02 from counter 8'h00 -> counter 8'h01 (modulo wrap).
- Load wr_data=8'h10 with requesters 1 and 2 valid (deltas 1 and 2) -> set_c, add_a and add_b all issued in the same cycle; counter reads 8'h13.
- Force write wr_data=8'hAA with all requesters valid -> req_ready=0 and ptr unchanged that cycle. Issue stage carries set_f=1, data_f=8'hAA and no adds. The following cycle resumes grants at the old ptr.
- en=0 for 4 cycles with all requesters valid -> no grants and ptr frozen. Reset asserted in the cycle after an accept -> the issue stage outputs 0 and the accepted adds are discarded.

Source files
------------

// File: rtl/bsc_counter_arbiter.sv
// Round-robin arbiter that shares a two-port-add counter's add, load and force
// inputs among NREQ requesters and one configuration writer, through a registered issue stage.
module bsc_counter_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_delta,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wr_valid,
    input  logic                  wr_force,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ready,
    output logic                  add_a,
    output logic                  add_b,
    output logic                  set_c,
    output logic                  set_f,
    output logic [WIDTH-1:0]      data_a,
    output logic [WIDTH-1:0]      data_b,
    output logic [WIDTH-1:0]      data_c,
    output logic [WIDTH-1:0]      data_f,
    output logic [1:0]            grant_count
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_next;
    logic [PW-1:0]    idx_a;
    logic [PW-1:0]    idx_b;
    logic             found_a;
    logic             found_b;
    logic             allow;
    logic             is_load;
    logic             is_force;
    logic [WIDTH-1:0] delta [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_delta
        assign delta[i] = req_delta[i*WIDTH +: WIDTH];
    end

    // A force-set owns the counter for its cycle, so it blocks every add grant.
    assign is_load  = wr_valid && !wr_force;
    assign is_force = wr_valid && wr_force;
    assign allow    = en && !reset && !is_force;
    assign wr_ready = wr_valid && !reset;

    always_comb begin : scan
        logic [PW:0] pos;
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
            if (allow && req_valid[pos[PW-1:0]]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = pos[PW-1:0];
                end else if (!found_b) begin
                    found_b = 1'b1;
                    idx_b   = pos[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (found_a && idx_a == PW'(i)) || (found_b && idx_b == PW'(i));
        end
    end

    // The pointer restarts just past the last requester served, wrapping at NREQ.
    always_comb begin : ptr_calc
        logic [PW:0] nxt;
        nxt = {1'b0, (found_b ? idx_b : idx_a)} + (PW+1)'(1);
        if (nxt == (PW+1)'(NREQ)) nxt = '0;
        ptr_next = found_a ? nxt[PW-1:0] : ptr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            add_a       <= 1'b0;
            add_b       <= 1'b0;
            set_c       <= 1'b0;
            set_f       <= 1'b0;
            data_a      <= '0;
            data_b      <= '0;
            data_c      <= '0;
            data_f      <= '0;
            grant_count <= 2'd0;
        end else begin
            ptr         <= ptr_next;
            add_a       <= found_a;
            add_b       <= found_b;
            data_a      <= found_a ? delta[idx_a] : '0;
            data_b      <= found_b ? delta[idx_b] : '0;
            set_c       <= is_load;
            set_f       <= is_force;
            data_c      <= is_load ? wr_data : '0;
            data_f      <= is_force ? wr_data : '0;
            grant_count <= found_b ? 2'd2 : (found_a ? 2'd1 : 2'd0);
        end
    end
endmodule

// File: tb/tb_bsc_counter_arbiter.sv
// Self-checking bench for bsc_counter_arbiter: fixed vector table, hand-built corner
// sequences, and random traffic checked against a queue-based arbitration model.
module tb_bsc_counter_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic        clk = 1'b0;
    logic        reset, en, wr_valid, wr_force, wr_ready;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_delta;
    logic [7:0]  wr_data;
    logic        add_a, add_b, set_c, set_f;
    logic [7:0]  data_a, data_b, data_c, data_f;
    logic [1:0]  grant_count;

    int          total = 0;
    int          bad = 0;
    int          m_ptr = 0;
    logic [7:0]  tb_q = 8'h00;
    logic [3:0]  seen_ready;

    typedef struct packed {
        logic       add_a, add_b, set_c, set_f;
        logic [7:0] da, db, dc, df;
        logic [1:0] gc;
    } bundle_t;

    typedef struct {
        logic       en;
        logic [3:0] rv, ready;
        logic       add_a;
        logic [7:0] da;
        logic       add_b;
        logic [7:0] db;
        logic [1:0] gc;
    } vec_t;

    vec_t tbl [8];

    bsc_counter_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .en(en),
        .req_valid(req_valid), .req_delta(req_delta), .req_ready(req_ready),
        .wr_valid(wr_valid), .wr_force(wr_force), .wr_data(wr_data), .wr_ready(wr_ready),
        .add_a(add_a), .add_b(add_b), .set_c(set_c), .set_f(set_f),
        .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_f(data_f),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock cycle: drive inputs, check grants, then check the issued bundle.
    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] rv,
                                 input logic [31:0] rd, input logic wv, input logic wf,
                                 input logic [7:0] wd);
        int         q[$];
        logic [3:0] er;
        bundle_t    nb;
        logic [7:0] nq;
        reset = r; en = e; req_valid = rv; req_delta = rd;
        wr_valid = wv; wr_force = wf; wr_data = wd;
        #2;
        q = {};
        if (!r && e && !(wv && wf))
            for (int k = 0; k < NREQ; k++)
                if (rv[(m_ptr + k) % NREQ]) q.push_back((m_ptr + k) % NREQ);
        while (q.size() > 2) void'(q.pop_back());
        er = 4'b0000;
        foreach (q[i]) er[q[i]] = 1'b1;
        checkOutput("req_ready", req_ready, er);
        checkOutput("wr_ready", wr_ready, wv && !r);
        seen_ready = req_ready;
        nb = '0;
        if (!r) begin
            if (q.size() > 0) begin nb.add_a = 1'b1; nb.da = rd[q[0]*8 +: 8]; end
            if (q.size() > 1) begin nb.add_b = 1'b1; nb.db = rd[q[1]*8 +: 8]; end
            nb.gc = 2'(q.size());
            if (wv && !wf) begin nb.set_c = 1'b1; nb.dc = wd; end
            if (wv && wf) begin nb.set_f = 1'b1; nb.df = wd; end
            if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % NREQ;
        end else begin
            m_ptr = 0;
        end
        nq = set_f ? data_f
                   : ((set_c ? data_c : tb_q) + (add_a ? data_a : 8'h00) + (add_b ? data_b : 8'h00));
        @(posedge clk);
        #1;
        tb_q = nq;
        checkOutput("add_a", add_a, nb.add_a);
        checkOutput("add_b", add_b, nb.add_b);
        checkOutput("set_c", set_c, nb.set_c);
        checkOutput("set_f", set_f, nb.set_f);
        checkOutput("data_a", data_a, nb.da);
        checkOutput("data_b", data_b, nb.db);
        checkOutput("data_c", data_c, nb.dc);
        checkOutput("data_f", data_f, nb.df);
        checkOutput("grant_count", grant_count, nb.gc);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 4'b1111, 4'b0011, 1'b1, 8'h11, 1'b1, 8'h22, 2'd2};
        tbl[1] = '{1'b1, 4'b1111, 4'b1100, 1'b1, 8'h33, 1'b1, 8'h44, 2'd2};
        tbl[2] = '{1'b1, 4'b1111, 4'b0011, 1'b1, 8'h11, 1'b1, 8'h22, 2'd2};
        tbl[3] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 8'h44, 1'b0, 8'h00, 2'd1};
        tbl[4] = '{1'b1, 4'b0100, 4'b0100, 1'b1, 8'h33, 1'b0, 8'h00, 2'd1};
        tbl[5] = '{1'b1, 4'b1001, 4'b1001, 1'b1, 8'h44, 1'b1, 8'h11, 2'd2};
        tbl[6] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0};
        tbl[7] = '{1'b1, 4'b1111, 4'b0110, 1'b1, 8'h22, 1'b1, 8'h33, 2'd2};

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 4'b1111, 32'h44332211, 1'b1, 1'b0, 8'h55);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, tbl[i].en, tbl[i].rv, 32'h44332211, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("tbl%0d_ready", i), seen_ready, tbl[i].ready);
            checkOutput($sformatf("tbl%0d_add_a", i), add_a, tbl[i].add_a);
            checkOutput($sformatf("tbl%0d_data_a", i), data_a, tbl[i].da);
            checkOutput($sformatf("tbl%0d_add_b", i), add_b, tbl[i].add_b);
            checkOutput($sformatf("tbl%0d_data_b", i), data_b, tbl[i].db);
            checkOutput($sformatf("tbl%0d_gc", i), grant_count, tbl[i].gc);
        end

        // Lone requester 3 from ptr 0; counter starts at zero.
        applyStimulus(1'b1, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00);
        tb_q = 8'h00;
        applyStimulus(1'b0, 1'b1, 4'b1000, 32'h05000000, 1'b0, 1'b0, 8'h00);
        checkOutput("single_ready", seen_ready, 4'b1000);
        idle();
        checkOutput("single_q", tb_q, 8'h05);

        // Zero delta still granted, force counter to 0, then wrap pair 3/0.
        applyStimulus(1'b0, 1'b1, 4'b0100, 32'h0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 4'b0000, 32'h0, 1'b1, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 4'b1001, 32'hFF000002, 1'b0, 1'b0, 8'h00);
        checkOutput("wrap_ready", seen_ready, 4'b1001);
        idle();
        checkOutput("wrap_q", tb_q, 8'h01);

        // Load merged with two adds.
        applyStimulus(1'b0, 1'b1, 4'b0110, 32'h00020100, 1'b1, 1'b0, 8'h10);
        checkOutput("load_merge", {set_c, add_a, add_b}, 3'b111);
        idle();
        checkOutput("load_q", tb_q, 8'h13);

        // Force blocks grants; next cycle resumes at the old pointer (3).
        applyStimulus(1'b0, 1'b1, 4'b1111, 32'h44332211, 1'b1, 1'b1, 8'hAA);
        checkOutput("force_ready", seen_ready, 4'b0000);
        applyStimulus(1'b0, 1'b1, 4'b1111, 32'h44332211, 1'b0, 1'b0, 8'h00);
        checkOutput("resume_ready", seen_ready, 4'b1001);
        checkOutput("force_q", tb_q, 8'hAA);

        // Enable low for four cycles freezes the pointer at 1.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, 4'b1111, 32'h44332211, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 4'b1111, 32'h44332211, 1'b0, 1'b0, 8'h00);
        checkOutput("en_resume_ready", seen_ready, 4'b0110);

        // Reset right after an accept clears the issue stage.
        applyStimulus(1'b0, 1'b1, 4'b1111, 32'h44332211, 1'b1, 1'b0, 8'h77);
        applyStimulus(1'b1, 1'b1, 4'b1111, 32'h44332211, 1'b0, 1'b0, 8'h00);
        checkOutput("rst_clear", {add_a, add_b, set_c, grant_count}, 5'b0);

        for (int n = 0; n < 300; n++)
            applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0, 4'($urandom),
                          $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                          8'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
